alu: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_shifter.sv | 20 ++
 rtl/alu.sv | 61 ++++++
 tb/tb_alu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and opcode encodings.
// Imported by the ALU and by the control unit that drives OP.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_SLL = 3'd2;
  localparam logic [OP_W-1:0] OP_SRA = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_AND = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR = 3'd6;
  localparam logic [OP_W-1:0] OP_SLT = 3'd7;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for the ALU: logical left or arithmetic right by amt.
// Arithmetic right shift sign-fills, so odd negatives round toward minus infinity.
module alu_shifter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               arith,
  output logic [WIDTH-1:0]   result
);

  always_comb begin
    result = a << amt;
    if (arith) begin
      result = WIDTH'($signed(a) >>> amt);
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational op mux into a result register that loads every cycle.
// ZERODETECT is registered alongside ALUOut so the two can never disagree.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OP_W-1:0]  OP,
  output logic [WIDTH-1:0] ALUOut,
  output logic             ZERODETECT
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] result;
  logic             arith;

  assign arith = (OP == OP_SRA);

  // Only the low bits of B select the shift distance; upper bits are ignored.
  alu_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .a     (A),
    .amt   (B[SHAMT_W-1:0]),
    .arith (arith),
    .result(shift_res)
  );

  always_comb begin
    result = '0;
    case (OP)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_SLL:  result = shift_res;
      OP_SRA:  result = shift_res;
      OP_OR:   result = A | B;
      OP_AND:  result = A & B;
      OP_XOR:  result = A ^ B;
      OP_SLT:  result = WIDTH'($signed(A) < $signed(B));
      default: result = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALUOut     <= '0;
      ZERODETECT <= 1'b1;
    end else begin
      ALUOut     <= result;
      ZERODETECT <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, random vectors against an
// arithmetic reference model, and hand-written reset / back-to-back sequences.
module tb_alu;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  OP;
  logic [15:0] ALUOut;
  logic        ZERODETECT;

  int tests;
  int failed;

  alu #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .ALUOut    (ALUOut),
    .ZERODETECT(ZERODETECT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%04h) required %0d (0x%04h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Reference model from the operation rules, using plain integer arithmetic.
  function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    int sa, sb, sh, d, q;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b) % 16;
    d  = 1 << sh;
    case (op)
      3'd0: return 16'(sa + sb);
      3'd1: return 16'(sa - sb);
      3'd2: return 16'(sa * d);
      3'd3: begin
        q = sa / d;
        if ((sa % d) != 0 && sa < 0) q = q - 1;
        return 16'(q);
      end
      3'd4: return a | b;
      3'd5: return a & b;
      3'd6: return a ^ b;
      default: return (sa < sb) ? 16'd1 : 16'd0;
    endcase
  endfunction

  task automatic apply_and_check(input string name, input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] exp);
    OP = op;
    A  = a;
    B  = b;
    @(posedge CLK);
    #1;
    check({name, ".out"}, ALUOut, exp);
    check({name, ".zero"}, 16'(ZERODETECT), 16'(exp == 16'd0));
  endtask

  initial begin
    logic [15:0] ra, rb, rexp;
    logic [2:0]  rop;
    tests  = 0;
    failed = 0;

    vecs.push_back('{"add1", 3'd0, 16'd1, 16'd1, 16'd2});
    vecs.push_back('{"add2", 3'd0, 16'd5, 16'd10, 16'd15});
    vecs.push_back('{"add_neg", 3'd0, 16'(-3), 16'(-5), 16'(-8)});
    vecs.push_back('{"add_wrap", 3'd0, 16'd32767, 16'd1, 16'h8000});
    vecs.push_back('{"sub_zero", 3'd1, 16'd1, 16'd1, 16'd0});
    vecs.push_back('{"sub_neg", 3'd1, 16'd5, 16'd10, 16'(-5)});
    vecs.push_back('{"sub_negneg", 3'd1, 16'(-3), 16'(-5), 16'd2});
    vecs.push_back('{"sll1", 3'd2, 16'd1, 16'd1, 16'd2});
    vecs.push_back('{"sll3", 3'd2, 16'd5, 16'd3, 16'd40});
    vecs.push_back('{"sll_neg", 3'd2, 16'(-3), 16'd2, 16'(-12)});
    vecs.push_back('{"sll_b17", 3'd2, 16'd1, 16'd17, 16'd2});
    vecs.push_back('{"sll_b16", 3'd2, 16'd7, 16'd16, 16'd7});
    vecs.push_back('{"sra1", 3'd3, 16'd20, 16'd1, 16'd10});
    vecs.push_back('{"sra2", 3'd3, 16'd11, 16'd2, 16'd2});
    vecs.push_back('{"sra_neg2", 3'd3, 16'(-12), 16'd2, 16'(-3)});
    vecs.push_back('{"sra_neg3", 3'd3, 16'(-12), 16'd3, 16'(-2)});
    vecs.push_back('{"sra_15", 3'd3, 16'h8000, 16'd15, 16'hFFFF});
    vecs.push_back('{"or1", 3'd4, 16'd1, 16'd2, 16'd3});
    vecs.push_back('{"or2", 3'd4, 16'd8, 16'd5, 16'd13});
    vecs.push_back('{"or_neg", 3'd4, 16'(-1), 16'd0, 16'(-1)});
    vecs.push_back('{"and1", 3'd5, 16'd1, 16'd1, 16'd1});
    vecs.push_back('{"and_zero", 3'd5, 16'd8, 16'd5, 16'd0});
    vecs.push_back('{"and_neg", 3'd5, 16'(-1), 16'd0, 16'd0});
    vecs.push_back('{"xor", 3'd6, 16'h00FF, 16'h0F0F, 16'h0FF0});
    vecs.push_back('{"slt_neg", 3'd7, 16'(-1), 16'd0, 16'd1});
    vecs.push_back('{"slt_pos", 3'd7, 16'd5, 16'(-5), 16'd0});
    vecs.push_back('{"slt_eq", 3'd7, 16'd7, 16'd7, 16'd0});

    // Reset holds the register at zero even with live inputs and clock edges.
    RST = 1'b0;
    A   = 16'd5;
    B   = 16'd3;
    OP  = 3'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset.out", ALUOut, 16'd0);
    check("reset.zero", 16'(ZERODETECT), 16'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("release.out", ALUOut, 16'd8);
    check("release.zero", 16'(ZERODETECT), 16'd0);

    foreach (vecs[i]) begin
      apply_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
    end

    // Back-to-back operations, one per cycle.
    apply_and_check("b2b_add", 3'd0, 16'd2, 16'd3, 16'd5);
    apply_and_check("b2b_sub", 3'd1, 16'd9, 16'd9, 16'd0);
    apply_and_check("b2b_or", 3'd4, 16'd4, 16'd1, 16'd5);

    // Inputs changing between edges must not reach the outputs.
    A  = 16'd100;
    B  = 16'd200;
    OP = 3'd0;
    #3;
    check("midcycle_hold.out", ALUOut, 16'd5);

    // Reset in the middle of a cycle clears the outputs before the next edge.
    apply_and_check("pre_rst", 3'd0, 16'd2, 16'd3, 16'd5);
    #2;
    RST = 1'b0;
    #1;
    check("midrst.out", ALUOut, 16'd0);
    check("midrst.zero", 16'(ZERODETECT), 16'd1);
    @(negedge CLK);
    RST = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (n % 8 == 0) rb = 16'($urandom_range(0, 40));
      if (n % 16 == 1) ra = rb;
      rexp = model(rop, ra, rb);
      apply_and_check($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, rexp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
